// File: rtl/sfifo_chan_packer.sv
// Multi-channel word FIFOs feeding a round-robin packer that emits one wide beat
// per grant. The beat carries up to WPB words, or fewer when a message closes early.
module sfifo_chan_packer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WORD_W = 64,
  parameter int unsigned OUT_W  = 512,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ID_W   = 22,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*WORD_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_en,
  output logic [LEN_W-1:0]         out_len,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready
);

  localparam int unsigned WPB = OUT_W / WORD_W;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SW  = ID_W - 8;

  // Elaboration-time parameter sanity checks.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..16");
  end
  if ((OUT_W % WORD_W) != 0) begin : g_bad_out_w
    $error("OUT_W must be a multiple of WORD_W");
  end
  if (DEPTH < WPB || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least OUT_W/WORD_W");
  end
  if (ID_W < 12) begin : g_bad_id_w
    $error("ID_W must be at least 12");
  end
  if (WPB >= (1 << LEN_W)) begin : g_bad_len_w
    $error("LEN_W too narrow to hold OUT_W/WORD_W");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  // Per-channel storage: bit WORD_W is the message-last flag.
  logic [WORD_W:0]  r_mem      [NUM_CH][DEPTH];
  logic [PW-1:0]    r_wr_ptr   [NUM_CH];
  logic [PW-1:0]    r_rd_ptr   [NUM_CH];
  logic [CW-1:0]    r_count    [NUM_CH];
  // Number of buffered entries carrying last=1; nonzero makes a channel eligible.
  logic [CW-1:0]    r_last_cnt [NUM_CH];
  logic [SW-1:0]    r_seq      [NUM_CH];

  state_e           r_state;
  logic [CHW-1:0]   r_grant;
  logic [CHW-1:0]   r_rr_ptr;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_en;
  logic [LEN_W-1:0] r_out_len;
  logic [ID_W-1:0]  r_out_id;

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_elig;
  logic              w_any_elig;
  logic [CHW-1:0]    w_pick;
  logic [OUT_W-1:0]  w_beat;
  logic [LEN_W-1:0]  w_len;
  logic              w_hit_last;
  logic [LEN_W-1:0]  w_pop_n    [NUM_CH];
  logic              w_pop_last [NUM_CH];

  assign out_data = r_out_data;
  assign out_en   = r_out_en;
  assign out_len  = r_out_len;
  assign out_id   = r_out_id;

  // Accept, push and eligibility per channel, all from registered counts.
  always_comb begin
    in_ready = '0;
    w_push   = '0;
    w_elig   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      in_ready[c] = (r_count[c] < CW'(DEPTH));
      w_push[c]   = in_valid[c] && in_ready[c];
      w_elig[c]   = (r_count[c] >= CW'(WPB)) || (r_last_cnt[c] != '0);
    end
  end

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    w_any_elig = 1'b0;
    w_pick     = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_CH;
      if (!w_any_elig && w_elig[idx]) begin
        w_any_elig = 1'b1;
        w_pick     = CHW'(idx);
      end
    end
  end

  // Gather the beat for the granted channel: up to WPB words, stopping after the
  // first last-flagged word.
  always_comb begin
    logic [PW-1:0]   addr;
    logic [WORD_W:0] ent;
    logic            stop;
    addr       = '0;
    ent        = '0;
    stop       = 1'b0;
    w_beat     = '0;
    w_len      = '0;
    w_hit_last = 1'b0;
    for (int i = 0; i < int'(WPB); i++) begin
      addr = PW'((int'(r_rd_ptr[r_grant]) + i) % DEPTH);
      ent  = r_mem[r_grant][addr];
      if (!stop && (CW'(i) < r_count[r_grant])) begin
        w_beat[i*WORD_W +: WORD_W] = ent[WORD_W-1:0];
        w_len = LEN_W'(i + 1);
        if (ent[WORD_W]) begin
          stop       = 1'b1;
          w_hit_last = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Pops happen only in LOAD, only on the granted channel.
  always_comb begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_pop_n[c]    = '0;
      w_pop_last[c] = 1'b0;
      if (r_state == StLoad && r_grant == CHW'(c)) begin
        w_pop_n[c]    = w_len;
        w_pop_last[c] = w_hit_last;
      end
    end
  end

  // FIFO write port; storage itself needs no reset since counts gate all reads.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wr_ptr[c]] <= {in_last[c], in_data[c*WORD_W +: WORD_W]};
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop net out in the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_wr_ptr[c]   <= '0;
        r_rd_ptr[c]   <= '0;
        r_count[c]    <= '0;
        r_last_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (w_push[c]) begin
          r_wr_ptr[c] <= PW'((int'(r_wr_ptr[c]) + 1) % DEPTH);
        end
        r_rd_ptr[c]   <= PW'((int'(r_rd_ptr[c]) + int'(w_pop_n[c])) % DEPTH);
        r_count[c]    <= r_count[c] + CW'(w_push[c]) - CW'(w_pop_n[c]);
        r_last_cnt[c] <= r_last_cnt[c] + CW'(w_push[c] && in_last[c]) - CW'(w_pop_last[c]);
      end
    end
  end

  // Control FSM with registered beat outputs and per-channel sequence numbers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_out_data <= '0;
      r_out_en   <= 1'b0;
      r_out_len  <= '0;
      r_out_id   <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_seq[c] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_elig) begin
            r_grant  <= w_pick;
            r_rr_ptr <= CHW'((int'(w_pick) + 1) % NUM_CH);
            r_state  <= StLoad;
          end
        end
        StLoad: begin
          r_out_data <= w_beat;
          r_out_len  <= w_len;
          r_out_id   <= {8'(r_grant), r_seq[r_grant]};
          r_out_en   <= 1'b1;
          r_state    <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            r_out_en       <= 1'b0;
            r_seq[r_grant] <= r_seq[r_grant] + SW'(1);
            r_state        <= StIdle;
          end
        end
        default: begin
          r_out_en <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

endmodule
